// File: rtl/rgb2gray_pipe.sv
// Three-stage RGB-to-luma converter with valid/ready on both sides: shifted terms,
// per-channel partial sums, then the saturated total, with per-pixel mode and frame-end tracking.
module rgb2gray_pipe #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] r,
    input  logic [DW-1:0] g,
    input  logic [DW-1:0] b,
    input  logic          in_last,
    input  logic [1:0]    mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] y,
    output logic          out_last,
    output logic [CW-1:0] pix_count
);

    localparam int SW = DW + 2;
    localparam logic [SW-1:0] Y_MAX = {2'b00, {DW{1'b1}}};

    logic                 en;
    logic [3:0][DW-1:0]   tr, tg, tb;
    logic                 s1_valid, s1_last;
    logic [1:0]           s1_mode;
    logic [3:0][DW-1:0]   s1_tr, s1_tg, s1_tb;
    logic [DW-1:0]        max_rg, max_rgb;
    logic [SW-1:0]        sum_r, sum_g, sum_b;
    logic                 s2_valid, s2_last;
    logic [SW-1:0]        s2_r, s2_g, s2_b;
    logic [SW-1:0]        total;
    logic [DW-1:0]        y_sat;
    logic [CW-1:0]        count_reg;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Mode 3 passes the raw components through; the max is taken in S2.
    always_comb begin
        tr = '0;
        tg = '0;
        tb = '0;
        case (mode)
            2'd0: begin
                tr[0] = r >> 2;
                tr[1] = r >> 5;
                tr[2] = r >> 6;
                tg[0] = g >> 1;
                tg[1] = g >> 4;
                tg[2] = g >> 6;
                tg[3] = g >> 7;
                tb[0] = b >> 4;
                tb[1] = b >> 5;
                tb[2] = b >> 6;
                tb[3] = b >> 7;
            end
            2'd1: begin
                tr[0] = r >> 2;
                tg[0] = g >> 1;
                tb[0] = b >> 2;
            end
            2'd2: begin
                tg[0] = g;
            end
            default: begin
                tr[0] = r;
                tg[0] = g;
                tb[0] = b;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_mode  <= 2'd0;
            s1_tr    <= '0;
            s1_tg    <= '0;
            s1_tb    <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_last <= in_last;
                s1_mode <= mode;
                s1_tr   <= tr;
                s1_tg   <= tg;
                s1_tb   <= tb;
            end
        end
    end

    assign max_rg  = (s1_tr[0] > s1_tg[0]) ? s1_tr[0] : s1_tg[0];
    assign max_rgb = (max_rg > s1_tb[0]) ? max_rg : s1_tb[0];

    always_comb begin
        sum_r = SW'(s1_tr[0]) + SW'(s1_tr[1]) + SW'(s1_tr[2]) + SW'(s1_tr[3]);
        sum_g = SW'(s1_tg[0]) + SW'(s1_tg[1]) + SW'(s1_tg[2]) + SW'(s1_tg[3]);
        sum_b = SW'(s1_tb[0]) + SW'(s1_tb[1]) + SW'(s1_tb[2]) + SW'(s1_tb[3]);
        if (s1_mode == 2'd3) begin
            sum_r = SW'(max_rgb);
            sum_g = '0;
            sum_b = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_r     <= '0;
            s2_g     <= '0;
            s2_b     <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_last <= s1_last;
                s2_r    <= sum_r;
                s2_g    <= sum_g;
                s2_b    <= sum_b;
            end
        end
    end

    assign total = s2_r + s2_g + s2_b;
    assign y_sat = (total > Y_MAX) ? Y_MAX[DW-1:0] : total[DW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            y         <= '0;
        end else if (en) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_last <= s2_last;
                y        <= y_sat;
            end
        end
    end

    // The register holds beats already sent in this frame; the port adds the beat on display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (out_valid && out_ready) begin
            count_reg <= out_last ? '0 : count_reg + CW'(1);
        end
    end

    assign pix_count = out_valid ? count_reg + CW'(1) : count_reg;

endmodule

// File: tb/tb_rgb2gray_pipe.sv
// Scoreboard bench for rgb2gray_pipe: drivers push expected beats, a negedge monitor pops and compares.
module tb_rgb2gray_pipe;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] r, g, b;
    logic          in_last;
    logic [1:0]    mode;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] y;
    logic          out_last;
    logic [CW-1:0] pix_count;

    rgb2gray_pipe #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .r(r), .g(g), .b(b), .in_last(in_last), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .out_last(out_last), .pix_count(pix_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int y;
        bit last;
        int cnt;
        int acc;
        bit lat;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   exp_cnt = 0;
    int   held;
    bit   done;
    int   pat[9] = '{1, 0, 1, 0, 0, 0, 0, 0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: luma from the per-mode shift rules, then clamp to the sample range.
    function automatic int model(input int rr, input int gg, input int bb, input int m);
        int v;
        case (m)
            0: v = (rr >> 2) + (rr >> 5) + (rr >> 6)
                 + (gg >> 1) + (gg >> 4) + (gg >> 6) + (gg >> 7)
                 + (bb >> 4) + (bb >> 5) + (bb >> 6) + (bb >> 7);
            1: v = (rr >> 2) + (gg >> 1) + (bb >> 2);
            2: v = gg;
            default: v = (rr > gg) ? ((rr > bb) ? rr : bb) : ((gg > bb) ? gg : bb);
        endcase
        if (v > (1 << DW) - 1) v = (1 << DW) - 1;
        return v;
    endfunction

    task automatic push_exp(input int ey, input bit l, input bit lat);
        exp_t x;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        x.y = ey; x.last = l; x.cnt = exp_cnt; x.acc = cyc; x.lat = lat;
        q.push_back(x);
        if (l) exp_cnt = 0;
    endtask

    // Called #1 after a posedge; returns #1 after the edge that took the pixel.
    task automatic send(input int rr, input int gg, input int bb, input int m,
                        input bit l, input int ey, input bit lat);
        r = DW'(rr); g = DW'(gg); b = DW'(bb); mode = 2'(m); in_last = l; in_valid = 1'b1;
        for (int k = 0; ; k++) begin
            @(negedge clk);
            if (in_ready) break;
            if (k > 200) begin
                checks++; failures++;
                $display("FAIL send_timeout actual=stalled required=accept");
                in_valid = 1'b0;
                return;
            end
        end
        push_exp(ey, l, lat);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_rand(input bit l);
        int rr, gg, bb, m;
        rr = $urandom_range(0, 255); gg = $urandom_range(0, 255);
        bb = $urandom_range(0, 255); m = $urandom_range(0, 3);
        send(rr, gg, bb, m, l, model(rr, gg, bb, m), 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; q.size() != 0; k++) begin
            @(negedge clk);
            if (k > 300) begin
                checks++; failures++;
                $display("FAIL drain_timeout actual=%0d required=0", q.size());
                q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready_rule", in_ready, (!out_valid || out_ready) ? 1 : 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_output actual=%0d required=none", y);
                end else begin
                    e = q.pop_front();
                    chk("y", y, e.y);
                    chk("out_last", out_last, e.last);
                    chk("pix_count", pix_count, e.cnt);
                    if (e.lat) chk("latency", cyc - e.acc, 3);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        r = '0; g = '0; b = '0; in_last = 1'b0; mode = 2'd0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_pix_count", pix_count, 0);
        #22 rst = 1'b0;
        @(posedge clk); #1;
        chk("release_in_ready", in_ready, 1);

        // Mode 0 singles
        send(255, 255, 255, 0, 1'b0, 245, 1'b1); drain();
        send(100, 0, 0, 0, 1'b0, 29, 1'b1);      drain();
        send(0, 200, 0, 0, 1'b0, 116, 1'b1);     drain();
        send(0, 0, 80, 0, 1'b0, 8, 1'b1);        drain();

        // All modes back-to-back
        send(255, 255, 255, 1, 1'b0, 253, 1'b1);
        send(10, 77, 200, 2, 1'b0, 77, 1'b1);
        send(10, 77, 200, 3, 1'b0, 200, 1'b1);
        send(100, 0, 0, 0, 1'b0, 29, 1'b1);
        drain();

        // Backpressure mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++) send_rand(1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (k == 0) held = y;
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_y", y, held);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Close the running frame, then a 4-pixel frame and the start of another
        send_rand(1'b1);
        for (int i = 0; i < 4; i++) send_rand(i == 3);
        send_rand(1'b0);
        send_rand(1'b1);
        drain();

        // Bubbles
        for (int i = 0; i < 9; i++) begin
            r = DW'(30 + i); g = DW'(60); b = DW'(90); mode = 2'd1; in_last = 1'b0;
            in_valid = pat[i][0];
            @(negedge clk);
            if (i >= 3) chk("bubble_out_valid", out_valid, pat[i - 3]);
            else        chk("bubble_out_valid", out_valid, 0);
            if (pat[i] != 0) push_exp(model(30 + i, 60, 90, 1), 1'b0, 1'b1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        // Random traffic with random backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send_rand($urandom_range(0, 7) == 0);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with three pixels in flight
        for (int i = 0; i < 3; i++) begin
            r = DW'(40); g = DW'(50 + i); b = DW'(60); mode = 2'd2; in_last = 1'b0;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("pre_reset_out_valid", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_y", y, 0);
        chk("async_rst_pix_count", pix_count, 0);
        q.delete();
        exp_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("post_rst_in_ready", in_ready, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_no_output", out_valid, 0);
        end
        @(posedge clk); #1;
        send(255, 255, 255, 1, 1'b1, 253, 1'b1);
        drain();

        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
